ccu_jump_n: RTL and testbench



---
 rtl/ccu_jump_n.sv | 121 ++++++++++++
 tb/tb_ccu_jump_n.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ccu_jump_n.sv
// Jump-handling control unit for N_ORD decoded transfer orders: issues the
// digit-timed sign test, decides whether the transfer is taken, and times the end pulse.
module ccu_jump_n #(
  parameter int unsigned      N_ORD      = 2,
  parameter logic [N_ORD-1:0] COND_MASK  = '1,
  parameter logic [N_ORD-1:0] COND_SENSE = N_ORD'(2'b01),
  parameter int unsigned      TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s2,
  input  logic [N_ORD-1:0] ord,
  input  logic             odd_d35,
  input  logic             ev_d0,
  input  logic             odd_d0,
  input  logic             test_valid,
  input  logic             test_resp,
  input  logic             ep_done,
  output logic             test_pulse,
  output logic             stop_sct,
  output logic             ep,
  output logic             busy,
  output logic             taken,
  output logic             err
);

  localparam int unsigned IW = (N_ORD > 1) ? $clog2(N_ORD) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_RESP,
    WAIT_EV,
    EP
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic            taken_q;
  logic            err_q;

  logic [IW-1:0]   ord_idx;
  logic            multi_hot;

  always_comb begin
    ord_idx = '0;
    for (int unsigned i = 0; i < N_ORD; i++) begin
      if (ord[i]) ord_idx = IW'(i);
    end
  end

  assign multi_hot = |(ord & (ord - N_ORD'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s2) begin
            if (multi_hot) begin
              err_q <= 1'b1;
            end else if (ord != '0) begin
              idx_q   <= ord_idx;
              state_q <= ARM;
            end
          end
        end
        ARM: begin
          // The test pulse is issued for every order; unconditional ones skip the response.
          if (odd_d35) begin
            if (COND_MASK[idx_q]) begin
              cnt_q   <= '0;
              state_q <= WAIT_RESP;
            end else begin
              taken_q <= 1'b1;
              state_q <= WAIT_EV;
            end
          end
        end
        WAIT_RESP: begin
          // A response arriving in the final timeout cycle still takes priority.
          if (test_valid) begin
            taken_q <= (test_resp == COND_SENSE[idx_q]);
            state_q <= WAIT_EV;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            taken_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= WAIT_EV;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_EV: begin
          if (ev_d0) state_q <= EP;
        end
        EP: begin
          if (ep_done) begin
            taken_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign test_pulse = (state_q == ARM) && odd_d35;
  assign stop_sct   = taken_q && ((state_q == WAIT_EV) || (state_q == EP));
  assign ep         = (state_q == EP) && odd_d0;
  assign busy       = (state_q != IDLE);
  assign taken      = taken_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ccu_jump_n.sv
// Directed bench for ccu_jump_n: two instances (default parameters, and
// order 0 unconditional with an 8-cycle timeout) checked against a flag-level model.
module tb_ccu_jump_n;

  logic       clk;
  logic       rst;
  logic       s2;
  logic [1:0] ord;
  logic       odd_d35, ev_d0, odd_d0, test_valid, test_resp, ep_done;
  logic [1:0] tp, ss, epo, bsy, tkn, er;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  ccu_jump_n u_a (
    .clk(clk), .rst(rst), .s2(s2), .ord(ord), .odd_d35(odd_d35), .ev_d0(ev_d0),
    .odd_d0(odd_d0), .test_valid(test_valid), .test_resp(test_resp), .ep_done(ep_done),
    .test_pulse(tp[0]), .stop_sct(ss[0]), .ep(epo[0]), .busy(bsy[0]), .taken(tkn[0]),
    .err(er[0])
  );

  ccu_jump_n #(.N_ORD(2), .COND_MASK(2'b10), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .s2(s2), .ord(ord), .odd_d35(odd_d35), .ev_d0(ev_d0),
    .odd_d0(odd_d0), .test_valid(test_valid), .test_resp(test_resp), .ep_done(ep_done),
    .test_pulse(tp[1]), .stop_sct(ss[1]), .ep(epo[1]), .busy(bsy[1]), .taken(tkn[1]),
    .err(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] MASK  [2] = '{2'b11, 2'b10};
  localparam logic [1:0] SENSE [2] = '{2'b01, 2'b01};
  localparam int         TMO   [2] = '{64, 8};

  // Transfer progress per instance: accepted, tested, decided, end-of-wait seen.
  typedef struct {
    bit act;
    bit tested;
    bit decided;
    bit ev_ok;
    bit tk;
    bit er;
    int idx;
    int t_test;
  } mdl_t;

  mdl_t m [2];
  int   cyc = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m[k] = '{default: 0};
      end else if (!m[k].act) begin
        if (s2 && $countones(ord) > 1) m[k].er = 1'b1;
        else if (s2 && $countones(ord) == 1) begin
          m[k].act = 1'b1; m[k].tested = 1'b0; m[k].decided = 1'b0;
          m[k].ev_ok = 1'b0; m[k].tk = 1'b0; m[k].idx = $clog2(ord);
        end
      end else if (!m[k].tested) begin
        if (odd_d35) begin
          m[k].tested = 1'b1;
          m[k].t_test = cyc;
          if (!MASK[k][m[k].idx]) begin
            m[k].decided = 1'b1; m[k].tk = 1'b1;
          end
        end
      end else if (!m[k].decided) begin
        if (test_valid) begin
          m[k].decided = 1'b1;
          m[k].tk = (test_resp == SENSE[k][m[k].idx]);
        end else if (cyc - m[k].t_test == TMO[k]) begin
          m[k].decided = 1'b1; m[k].tk = 1'b0; m[k].er = 1'b1;
        end
      end else if (!m[k].ev_ok) begin
        if (ev_d0) m[k].ev_ok = 1'b1;
      end else if (ep_done) begin
        m[k].act = 1'b0; m[k].tk = 1'b0;
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("test_pulse[%0d]@%0d", k, cyc), 32'(tp[k]),
            32'(m[k].act && !m[k].tested && odd_d35));
        chk($sformatf("stop_sct[%0d]@%0d", k, cyc), 32'(ss[k]),
            32'(m[k].act && m[k].decided && m[k].tk));
        chk($sformatf("ep[%0d]@%0d", k, cyc), 32'(epo[k]),
            32'(m[k].act && m[k].ev_ok && odd_d0));
        chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(bsy[k]), 32'(m[k].act));
        chk($sformatf("taken[%0d]@%0d", k, cyc), 32'(tkn[k]), 32'(m[k].tk));
        chk($sformatf("err[%0d]@%0d", k, cyc), 32'(er[k]), 32'(m[k].er));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    s2 = 1'b0; odd_d35 = 1'b0; ev_d0 = 1'b0; odd_d0 = 1'b0;
    test_valid = 1'b0; ep_done = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; s2 = 1'b0; ord = '0; odd_d35 = 1'b0; ev_d0 = 1'b0; odd_d0 = 1'b0;
    test_valid = 1'b0; test_resp = 1'b0; ep_done = 1'b0;
    step(); step();
    #2;
    chk("reset_busy", 32'(bsy), 0);  chk("reset_taken", 32'(tkn), 0);
    chk("reset_err", 32'(er), 0);    chk("reset_stop_sct", 32'(ss), 0);
    rst = 1'b0; run_chk = 1'b1;

    // Conditional take on A, unconditional on B; odd_d35 with s2 and ev_d0 in test cycle ignored.
    s2 = 1'b1; ord = 2'b01; odd_d35 = 1'b1; step();
    step();
    odd_d35 = 1'b1; ev_d0 = 1'b1; step();
    test_valid = 1'b1; test_resp = 1'b1; step();
    #2 chk("A_cond_taken", 32'(tkn[0]), 1); chk("B_uncond_taken", 32'(tkn[1]), 1);
    chk("A_stop_sct_wait_ev", 32'(ss[0]), 1);
    ev_d0 = 1'b1; step();
    odd_d0 = 1'b1; step();
    odd_d0 = 1'b1; ep_done = 1'b1; step();
    #2 chk("A_idle_after_done", 32'(bsy[0]), 0); chk("A_taken_cleared", 32'(tkn[0]), 0);

    // Conditional not taken on A.
    s2 = 1'b1; ord = 2'b01; step();
    odd_d35 = 1'b1; step();
    step();
    test_valid = 1'b1; test_resp = 1'b0; step();
    #2 chk("A_not_taken", 32'(tkn[0]), 0); chk("A_no_stop_sct", 32'(ss[0]), 0);
    ev_d0 = 1'b1; step();
    odd_d0 = 1'b1; ep_done = 1'b1; step();

    // Response in the final timeout cycle of B.
    s2 = 1'b1; ord = 2'b10; step();
    odd_d35 = 1'b1; step();
    repeat (7) step();
    test_valid = 1'b1; test_resp = 1'b0; step();
    #2 chk("B_tie_err", 32'(er[1]), 0); chk("B_tie_taken", 32'(tkn[1]), 1);
    ev_d0 = 1'b1; step();
    odd_d0 = 1'b1; ep_done = 1'b1; step();

    // Timeout on B, with a stray s2 while busy; A answered later.
    s2 = 1'b1; ord = 2'b10; step();
    odd_d35 = 1'b1; step();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (er[1] == 1'b0) n++;
      if (i == 3) begin s2 = 1'b1; ord = 2'b01; end
      step();
    end
    chk("B_timeout_cycles", 32'(n), 8);
    test_valid = 1'b1; test_resp = 1'b1; step();
    ev_d0 = 1'b1; step();
    #2 chk("B_timeout_taken", 32'(tkn[1]), 0); chk("B_timeout_err", 32'(er[1]), 1);
    chk("A_no_timeout_err", 32'(er[0]), 0);
    odd_d0 = 1'b1; ep_done = 1'b1; step();
    rst = 1'b1; step();
    rst = 1'b0;
    #2 chk("B_err_cleared_by_rst", 32'(er[1]), 0);

    // Multi-hot order.
    s2 = 1'b1; ord = 2'b11; step();
    #2 chk("A_multihot_err", 32'(er[0]), 1); chk("A_multihot_busy", 32'(bsy[0]), 0);

    // Reset while in EP drops the pending end pulse.
    s2 = 1'b1; ord = 2'b01; step();
    odd_d35 = 1'b1; step();
    test_valid = 1'b1; test_resp = 1'b1; step();
    ev_d0 = 1'b1; step();
    odd_d0 = 1'b1; rst = 1'b1; step();
    rst = 1'b0; odd_d0 = 1'b1;
    #2 chk("A_rst_ep", 32'(epo[0]), 0); chk("A_rst_busy", 32'(bsy[0]), 0);
    chk("A_rst_err", 32'(er[0]), 0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
